// File: rtl/stage_mem.sv
// stage_mem: memory stage of the pipeline.
// Issues one data-bus access per load/store, stalls the pipeline while the bus
// cycle is open, and reports completion, the extended load result and faults.
// A bus wait that reaches TIMEOUT_CYCLES is aborted and reported as a fault.
// Build option MEM_MISALIGN_EXC_EN: misaligned accesses raise an address-misaligned
// exception instead of being issued. Without it, the offending low address bits
// are cleared and the access goes out on the bus.
//
// state  | meaning
// IDLE   | waiting for a load/store, bus idle
// BUS    | bus cycle open, waiting for ack/err/timeout
// DONE   | one-cycle completion, done_o and fault pulses valid
module stage_mem #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        is_ld_inst_i,
  input  logic        is_st_inst_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_dat_i,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_dat_o,
  output logic [3:0]  dmem_sel_o,
  output logic        dmem_we_o,
  output logic        dmem_cyc_o,
  output logic        dmem_stb_o,
  input  logic [31:0] dmem_dat_i,
  input  logic        dmem_ack_i,
  input  logic        dmem_err_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] ld_dat_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_ld_fault_o,
  output logic        e_st_fault_o
);

  // Counter is one value wider than needed so count+1 can never wrap.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [3:0]        sel_q, sel_d;
  logic [2:0]        fn_q, fn_d;
  logic              done_q, done_d;
  logic              ld_fault_q, ld_fault_d;
  logic              st_fault_q, st_fault_d;
  logic [31:0]       ld_dat_q, ld_dat_d;

  logic              is_mem;
  logic              start;
  logic              sz_b, sz_h, sz_w;
  logic [31:0]       eff_addr;
  logic [3:0]        sel_c;
  logic [31:0]       wdat_c;
  logic [31:0]       ld_shift;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  // Request decode, alignment handling and misalign exception pulses.
  always_comb begin
    is_mem = valid_i & (is_ld_inst_i | is_st_inst_i);
    sz_b   = (funct3_i[1:0] == 2'b00);
    sz_h   = (funct3_i[1:0] == 2'b01);
    sz_w   = ~sz_b & ~sz_h;
`ifdef MEM_MISALIGN_EXC_EN
    eff_addr        = addr_i;
    start           = is_mem & ~((sz_h & addr_i[0]) | (sz_w & (addr_i[1:0] != 2'b00)));
    e_ld_addr_mis_o = (state_q == S_IDLE) & is_mem & ~start & ~is_st_inst_i;
    e_st_addr_mis_o = (state_q == S_IDLE) & is_mem & ~start & is_st_inst_i;
`else
    eff_addr        = addr_i;
    if (sz_w) eff_addr[1:0] = 2'b00;
    if (sz_h) eff_addr[0]   = 1'b0;
    start           = is_mem;
    e_ld_addr_mis_o = 1'b0;
    e_st_addr_mis_o = 1'b0;
`endif
  end

  // Byte-lane select and store data replication for the outgoing access.
  always_comb begin
    if (sz_b) begin
      sel_c  = 4'b0001 << eff_addr[1:0];
      wdat_c = {4{st_dat_i[7:0]}};
    end else if (sz_h) begin
      sel_c  = 4'b0011 << eff_addr[1:0];
      wdat_c = {2{st_dat_i[15:0]}};
    end else begin
      sel_c  = 4'hF;
      wdat_c = st_dat_i;
    end
  end

  // Load lane extraction and sign/zero extension from the returned bus word.
  always_comb begin
    ld_shift = dmem_dat_i >> {addr_q[1:0], 3'b000};
    ld_half  = addr_q[1] ? dmem_dat_i[31:16] : dmem_dat_i[15:0];
    case (fn_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dmem_dat_i;
    endcase
  end

  // Next-state logic: bus request registers, wait counter and completion pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    sel_d      = sel_q;
    fn_d       = fn_q;
    done_d     = 1'b0;
    ld_fault_d = 1'b0;
    st_fault_d = 1'b0;
    ld_dat_d   = ld_dat_q;
    cnt_inc    = cnt_q + 1'b1;
    // A TIMEOUT_CYCLES of zero aborts on the first bus cycle.
    timeout_hit = (cnt_inc >= TO_CNT);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUS;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          we_d    = is_st_inst_i;
          addr_d  = eff_addr;
          wdat_d  = wdat_c;
          sel_d   = sel_c;
          fn_d    = funct3_i;
        end
      end
      S_BUS: begin
        cnt_d = (cnt_q == TO_CNT) ? cnt_q : cnt_inc;
        if (dmem_ack_i | dmem_err_i | timeout_hit) begin
          state_d = S_DONE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          // err wins over a simultaneous ack; a late ack on the timeout cycle still counts.
          if (dmem_err_i | ~dmem_ack_i) begin
            ld_fault_d = ~we_q;
            st_fault_d = we_q;
          end else if (~we_q) begin
            ld_dat_d = ld_ext;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      sel_q      <= '0;
      fn_q       <= '0;
      done_q     <= 1'b0;
      ld_fault_q <= 1'b0;
      st_fault_q <= 1'b0;
      ld_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      sel_q      <= sel_d;
      fn_q       <= fn_d;
      done_q     <= done_d;
      ld_fault_q <= ld_fault_d;
      st_fault_q <= st_fault_d;
      ld_dat_q   <= ld_dat_d;
    end
  end

  // Stall covers the request cycle in IDLE and every BUS cycle.
  always_comb begin
    stall_o      = ((state_q == S_IDLE) & start) | (state_q == S_BUS);
    dmem_cyc_o   = cyc_q;
    dmem_stb_o   = cyc_q;
    dmem_we_o    = we_q;
    dmem_addr_o  = addr_q;
    dmem_dat_o   = wdat_q;
    dmem_sel_o   = sel_q;
    done_o       = done_q;
    ld_dat_o     = ld_dat_q;
    e_ld_fault_o = ld_fault_q;
    e_st_fault_o = st_fault_q;
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem, built with TIMEOUT_CYCLES = 4.
module tb_stage_mem;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, is_ld_inst_i, is_st_inst_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, st_dat_i;
  logic [31:0] dmem_addr_o, dmem_dat_o;
  logic [3:0]  dmem_sel_o;
  logic        dmem_we_o, dmem_cyc_o, dmem_stb_o;
  logic [31:0] dmem_dat_i;
  logic        dmem_ack_i, dmem_err_i;
  logic        stall_o, done_o;
  logic [31:0] ld_dat_o;
  logic        e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_fault_o, e_st_fault_o;

  int n_chk  = 0;
  int n_pass = 0;
  int stall_n;

  always #5 clk_i = ~clk_i;

  stage_mem #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .is_ld_inst_i(is_ld_inst_i), .is_st_inst_i(is_st_inst_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .st_dat_i(st_dat_i),
    .dmem_addr_o(dmem_addr_o), .dmem_dat_o(dmem_dat_o), .dmem_sel_o(dmem_sel_o),
    .dmem_we_o(dmem_we_o), .dmem_cyc_o(dmem_cyc_o), .dmem_stb_o(dmem_stb_o),
    .dmem_dat_i(dmem_dat_i), .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i),
    .stall_o(stall_o), .done_o(done_o), .ld_dat_o(ld_dat_o),
    .e_ld_addr_mis_o(e_ld_addr_mis_o), .e_st_addr_mis_o(e_st_addr_mis_o),
    .e_ld_fault_o(e_ld_fault_o), .e_st_fault_o(e_st_fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Present a request in IDLE and advance into the first BUS cycle.
  task automatic start(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    valid_i = 1'b1; is_ld_inst_i = ld; is_st_inst_i = st;
    funct3_i = f3; addr_i = a; st_dat_i = sd;
    tick;
  endtask

  // Drive the bus response for one cycle, landing in DONE.
  task automatic finish(input logic ack, input logic err, input logic [31:0] rd);
    dmem_ack_i = ack; dmem_err_i = err; dmem_dat_i = rd;
    tick;
    dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
  endtask

  task automatic retire;
    valid_i = 1'b0; is_ld_inst_i = 1'b0; is_st_inst_i = 1'b0;
    tick;
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; is_ld_inst_i = 1'b0; is_st_inst_i = 1'b0;
    funct3_i = 3'b000; addr_i = '0; st_dat_i = '0;
    dmem_dat_i = '0; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
    tick; tick;
    chkb("rst_cyc", dmem_cyc_o, 1'b0);
    chkb("rst_stall", stall_o, 1'b0);
    chkb("rst_done", done_o, 1'b0);
    chk("rst_ld_dat", ld_dat_o, 32'h0);
    rst_i = 1'b0;
    tick;

    // LW at 0x100, ack on the third bus cycle.
    valid_i = 1'b1; is_ld_inst_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h100;
    #1;
    stall_n = 0;
    chkb("lw_stall_req", stall_o, 1'b1); stall_n += int'(stall_o);
    chkb("lw_no_cyc_yet", dmem_cyc_o, 1'b0);
    tick;
    chkb("lw_cyc", dmem_cyc_o, 1'b1);
    chkb("lw_stb", dmem_stb_o, 1'b1);
    chk("lw_addr", dmem_addr_o, 32'h100);
    chk("lw_sel", {28'h0, dmem_sel_o}, 32'hF);
    chkb("lw_we", dmem_we_o, 1'b0);
    stall_n += int'(stall_o);
    tick; stall_n += int'(stall_o);
    tick; stall_n += int'(stall_o);
    finish(1'b1, 1'b0, 32'hDEADBEEF);
    chk("lw_stall_cycles", stall_n, 32'd4);
    chkb("lw_done", done_o, 1'b1);
    chkb("lw_stall_done", stall_o, 1'b0);
    chkb("lw_cyc_done", dmem_cyc_o, 1'b0);
    chk("lw_data", ld_dat_o, 32'hDEADBEEF);
    chkb("lw_no_fault", e_ld_fault_o, 1'b0);
    retire;
    chkb("lw_done_one_cycle", done_o, 1'b0);
    chk("lw_data_hold", ld_dat_o, 32'hDEADBEEF);

    // Load extension cases.
    start(1'b1, 1'b0, 3'b000, 32'h103, 32'h0); finish(1'b1, 1'b0, 32'h80000000);
    chk("lb_sext", ld_dat_o, 32'hFFFFFF80); retire;
    start(1'b1, 1'b0, 3'b100, 32'h103, 32'h0); finish(1'b1, 1'b0, 32'h80000000);
    chk("lbu_zext", ld_dat_o, 32'h00000080); retire;
    start(1'b1, 1'b0, 3'b001, 32'h102, 32'h0); finish(1'b1, 1'b0, 32'h80010000);
    chk("lh_sext_hi", ld_dat_o, 32'hFFFF8001); retire;
    start(1'b1, 1'b0, 3'b101, 32'h000, 32'h0); finish(1'b1, 1'b0, 32'hF00D1234);
    chk("lhu_zext_lo", ld_dat_o, 32'h00001234); retire;

    // Stores: lane select and replicated data; load result must hold.
    start(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD);
    chk("sh_sel", {28'h0, dmem_sel_o}, 32'hC);
    chk("sh_dat", dmem_dat_o, 32'hABCDABCD);
    chkb("sh_we", dmem_we_o, 1'b1);
    finish(1'b1, 1'b0, 32'h55555555);
    chkb("sh_done", done_o, 1'b1);
    chk("sh_ld_hold", ld_dat_o, 32'h00001234);
    retire;
    start(1'b0, 1'b1, 3'b000, 32'h001, 32'h000000A5);
    chk("sb_sel", {28'h0, dmem_sel_o}, 32'h2);
    chk("sb_dat", dmem_dat_o, 32'hA5A5A5A5);
    finish(1'b1, 1'b0, 32'h0); retire;

    // Store error and load with simultaneous ack+err.
    start(1'b0, 1'b1, 3'b010, 32'h400, 32'h11223344);
    finish(1'b0, 1'b1, 32'h0);
    chkb("sw_err_fault", e_st_fault_o, 1'b1);
    chkb("sw_err_no_ldfault", e_ld_fault_o, 1'b0);
    chkb("sw_err_done", done_o, 1'b1);
    retire;
    chkb("sw_fault_one_cycle", e_st_fault_o, 1'b0);
    start(1'b1, 1'b0, 3'b010, 32'h404, 32'h0);
    finish(1'b1, 1'b1, 32'h99999999);
    chkb("ackerr_fault", e_ld_fault_o, 1'b1);
    chk("ackerr_ld_hold", ld_dat_o, 32'h00001234);
    retire;

    // Timeout: no ack, bus open for exactly 4 cycles.
    start(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chkb($sformatf("to_cyc_%0d", i), dmem_cyc_o, 1'b1);
      chkb($sformatf("to_nodone_%0d", i), done_o, 1'b0);
      tick;
    end
    chkb("to_cyc_drop", dmem_cyc_o, 1'b0);
    chkb("to_done", done_o, 1'b1);
    chkb("to_fault", e_ld_fault_o, 1'b1);
    chk("to_ld_hold", ld_dat_o, 32'h00001234);
    retire;

    // Wait counter restarts: ack on the third cycle completes cleanly.
    start(1'b1, 1'b0, 3'b010, 32'h504, 32'h0);
    tick; tick;
    finish(1'b1, 1'b0, 32'hCAFEF00D);
    chkb("cnt_clear_no_fault", e_ld_fault_o, 1'b0);
    chk("cnt_clear_data", ld_dat_o, 32'hCAFEF00D);
    retire;

    // Misaligned LH at 0x301.
`ifdef MEM_MISALIGN_EXC_EN
    valid_i = 1'b1; is_ld_inst_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h301;
    #1;
    chkb("mis_ld_exc", e_ld_addr_mis_o, 1'b1);
    chkb("mis_st_exc", e_st_addr_mis_o, 1'b0);
    chkb("mis_stall", stall_o, 1'b0);
    tick;
    chkb("mis_no_cyc", dmem_cyc_o, 1'b0);
    retire;
`else
    start(1'b1, 1'b0, 3'b001, 32'h301, 32'h0);
    chk("mis_addr_forced", dmem_addr_o, 32'h300);
    chk("mis_sel", {28'h0, dmem_sel_o}, 32'h3);
    chkb("mis_ld_exc_tied", e_ld_addr_mis_o, 1'b0);
    finish(1'b1, 1'b0, 32'h0000BEEF);
    chk("mis_data", ld_dat_o, 32'hFFFFBEEF);
    retire;
`endif

    // Reset in the middle of a store bus cycle; a later ack is ignored.
    start(1'b0, 1'b1, 3'b010, 32'h600, 32'h77777777);
    tick;
    rst_i = 1'b1; valid_i = 1'b0; is_st_inst_i = 1'b0;
    tick;
    chkb("midrst_cyc", dmem_cyc_o, 1'b0);
    chkb("midrst_stb", dmem_stb_o, 1'b0);
    chkb("midrst_we", dmem_we_o, 1'b0);
    chkb("midrst_stall", stall_o, 1'b0);
    chk("midrst_ld_dat", ld_dat_o, 32'h0);
    chk("midrst_addr", dmem_addr_o, 32'h0);
    rst_i = 1'b0;
    dmem_ack_i = 1'b1;
    tick;
    dmem_ack_i = 1'b0;
    chkb("late_ack_no_done", done_o, 1'b0);
    chkb("late_ack_no_fault", e_st_fault_o, 1'b0);
    tick;
    chkb("late_ack_no_done2", done_o, 1'b0);
    chkb("late_ack_cyc", dmem_cyc_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus-wait cycles before an access is aborted as a fault.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port valid_i  input  1  execute-stage instruction valid.
REQ-005 SHALL have ports is_ld_inst_i / is_st_inst_i  input  1 each  load / store instruction.
REQ-006 SHALL have port funct3_i  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have port addr_i  input  32  effective address (execute ALU result).
REQ-008 SHALL have port st_dat_i  input  32  store data, rs2.
REQ-009 SHALL have data-bus outputs dmem_addr_o 32, dmem_dat_o 32, dmem_sel_o 4, dmem_we_o 1, dmem_cyc_o 1, dmem_stb_o 1.
REQ-010 SHALL have data-bus inputs dmem_dat_i 32, dmem_ack_i 1, dmem_err_i 1.
REQ-011 SHALL have port stall_o  output  1  upstream must hold all inputs stable while high.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse: access finished.
REQ-013 SHALL have port ld_dat_o  output  32  extended load result, valid with done_o.
REQ-014 SHALL have ports e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_fault_o, e_st_fault_o  output  1 each  exception pulses.

Function
REQ-015 SHALL implement FSM IDLE -> BUS -> DONE -> IDLE.
REQ-016 IDLE: valid_i & (is_ld_inst_i | is_st_inst_i) & aligned SHALL assert stall_o combinationally and move to BUS.
REQ-017 BUS: cyc/stb/addr/dat/sel/we SHALL be registered and held constant until ack, err or timeout.
REQ-018 stall_o SHALL stay high in BUS and drop in the DONE cycle.
REQ-019 BUS -> DONE on dmem_ack_i, dmem_err_i, or wait counter = TIMEOUT_CYCLES; cyc/stb SHALL deassert in DONE.
REQ-020 ack and err in the same cycle SHALL be treated as err.
REQ-021 Timeout SHALL be treated as err.
REQ-022 Wait counter SHALL clear on BUS entry and SHALL saturate, never wrap.
REQ-023 DONE: done_o = 1 for exactly one cycle.
REQ-024 DONE after err SHALL pulse e_ld_fault_o or e_st_fault_o by access type.
REQ-025 ld_dat_o SHALL be latched on ack for loads only; after store or fault it SHALL hold its previous value.
REQ-026 Load extraction: lane = addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-027 Store sel: B = 4'b0001 << addr[1:0]; H = 4'b0011 << addr[1:0]; W = 4'hF.
REQ-028 Store data: B replicated ×4; H replicated ×2.
REQ-029 dmem_we_o = 1 for stores only.
REQ-030 Misaligned means: H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0.
REQ-031 valid_i low, or neither load nor store, SHALL cause no bus activity and stall_o = 0.

Reset
REQ-032 rst_i SHALL force IDLE and clear counter, cyc, stb, we, done_o, ld_dat_o and all exceptions to 0 at the next edge, including mid-BUS.
REQ-033 An ack arriving after reset SHALL be ignored.

Configuration
REQ-034 With MEM_MISALIGN_EXC_EN defined, a misaligned access in IDLE SHALL pulse e_ld_addr_mis_o or e_st_addr_mis_o combinationally, issue no bus cycle, and keep stall_o = 0.
REQ-035 Without MEM_MISALIGN_EXC_EN, both misalign outputs SHALL be tied 0 and the access SHALL be issued with the offending low address bits forced to 0.

Verification
REQ-036 LW at 0x100, ack after 3 cycles with dmem_dat_i = 0xDEADBEEF -> stall_o high 4 cycles, then done_o, ld_dat_o = 0xDEADBEEF.
REQ-037 LB at 0x103 with dmem_dat_i = 0x80000000 -> ld_dat_o = 0xFFFFFF80; LBU gives 0x00000080.
REQ-038 SH at 0x202, st_dat_i = 0x1234ABCD -> dmem_sel_o = 4'b1100, dmem_dat_o = 0xABCDABCD, dmem_we_o = 1.
REQ-039 LW with no ack, TIMEOUT_CYCLES = 4 -> cyc drops after 4 wait cycles, done_o and e_ld_fault_o pulse together.
REQ-040 LH at 0x301, macro defined -> e_ld_addr_mis_o = 1, no dmem_cyc_o; macro undefined -> bus address 0x300.
REQ-041 rst_i asserted in BUS, then ack -> cyc = 0 next cycle, no done_o, all outputs 0.
